regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Command sequencer that drives the W-bit register file's ports: write data, write enable, write address and both read addresses, plus the two read data words returned to it. It accepts single write, dual read, fill and dump commands over a valid/ready command channel and returns read data over a valid/ready response channel. It sits between a host or test controller and the register file, and is the only agent that writes or reads it.

## Interface

- W, 4, register data width
- AW, 2, register address width (2^AW registers, AW >= 1)

- CLK  in  1  clock; all state changes on the rising edge
- RES  in  1  synchronous active-high reset, shared with the register file
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high at a CLK edge
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 DUMP
- cmd_addr  in  AW  write address (WRITE); port-0 read address (READ)
- cmd_addr_b  in  AW  port-1 read address (READ)
- cmd_data  in  W  write data (WRITE, FILL)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high at a CLK edge
- rsp_addr  out  AW  address read through port 0 for this response
- rsp_data  out  2W  {port-1 word, port-0 word}
- InA  out  W  register file write data
- WEN  out  1  register file write enable
- Add2  out  AW  register file write address
- Add0, Add1  out  AW  register file read addresses
- Out0, Out1  in  W  register file read data

## Operation

- Register file contract: reads are combinational from Add0/Add1; a write takes effect on the CLK edge with WEN=1; RES=1 clears every register.
- States: IDLE, WR, RD, FILL, DRD, RSP.
- cmd_ready = (state==IDLE) && !RES. Fields are latched on acceptance.
- WRITE: IDLE->WR. WR drives WEN=1, Add2=addr, InA=data for one cycle, then returns to IDLE.
- READ: IDLE->RD. RD drives Add0=cmd_addr and Add1=cmd_addr_b, then captures {Out1,Out0} and addr into the response registers and moves to RSP.
- FILL: IDLE->FILL. Index i counts 0..2^AW-1, with WEN=1, Add2=i, InA=data each cycle. After the last index the block returns to IDLE.
- DUMP: pair index p counts 0..2^(AW-1)-1.
  - DRD drives Add0=2p and Add1=2p+1, then captures into the response registers (rsp_addr=2p) and moves to RSP.
  - RSP, on handshake: if pairs remain, increment p and go to DRD; otherwise go to IDLE.
- RSP: rsp_valid=1. rsp_data and rsp_addr stay stable until the handshake, then the block goes to IDLE (or DRD during DUMP).
- Outside WR and FILL: WEN=0, InA=0, Add2=0. Outside RD and DRD: Add0=Add1=0.
- WEN is combinationally gated by !RES, so no register file write occurs in a reset cycle.
- Reset outputs: rsp_valid=0, rsp_data=0, rsp_addr=0, WEN=0, all addresses 0, state IDLE. cmd_ready=0 while RES=1 and 1 in the first cycle after.
- Reset mid-operation aborts it. Any pending response is discarded and no partial fill resumes.
- Index arithmetic is AW bits wide. The final-index compare uses all-ones, not wrap-around.

## Timing

- Command accepted at edge k:
  - WRITE: register updated at edge k+1; cmd_ready=1 after k+1.
  - READ: rsp_valid=1 after edge k+1. If rsp_ready is held high, the handshake occurs at edge k+2 and cmd_ready=1 after k+2.
  - FILL: writes occur at edges k+1..k+2^AW; cmd_ready=1 after k+2^AW.
  - DUMP: with rsp_ready=1, each pair takes 2 cycles, giving 2^AW cycles total before IDLE.
- rsp_ready low stalls indefinitely in RSP with no output change.
- rsp_ready may be high before rsp_valid; no combinational path exists from rsp_ready to rsp_valid.

## Configuration

- REGFILE_ACCESS_WACK_EN, when defined: WR goes to RSP instead of IDLE, with rsp_addr=write address and rsp_data={W'b0, written data}. WRITE latency then matches READ.
- When undefined: WRITE produces no response, and rsp_valid is never set by WRITE.

## Test plan

- WRITE addr0=4'b1100, WRITE addr1=4'b0011, READ(0,1) -> rsp_data=8'b0011_1100, rsp_addr=0, rsp_valid one cycle after the read state.
- FILL 4'hA, then DUMP with rsp_ready=1 -> two responses {A,A} with rsp_addr 0 then 2, then cmd_ready=1.
- READ(3,3) after WRITE addr3=4'b0001 with rsp_ready low for 3 cycles -> rsp_data=8'h11 stable throughout, cmd_ready=0, single handshake.
- FILL 4'h5 with RES=1 after 2 writes -> WEN=0 in the reset cycle, then DUMP returns all zero and rsp_valid=0 right after reset.
- cmd_valid=1 with RES=1 -> cmd_ready=0 and no register written.
- With REGFILE_ACCESS_WACK_EN, WRITE addr2=4'h7 -> rsp_addr=2, rsp_data=8'h07; without it -> no rsp_valid.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command sequencer in front of a two-read / one-write
// register file. Accepts WRITE, READ, FILL and DUMP commands on a valid/ready
// channel and returns read words on a valid/ready response channel.
// All register-file drive outputs come from flops; WEN and cmd_ready are
// additionally gated by RES so that nothing is written or accepted in a
// reset cycle.
// Optional feature: define REGFILE_ACCESS_WACK_EN to make WRITE return a
// response ({W'b0, written data} at the write address).
module regfile_access_ctrl #(
    parameter int W  = 4,
    parameter int AW = 2
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [AW-1:0]     cmd_addr_b,
    input  logic [W-1:0]      cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [AW-1:0]     rsp_addr,
    output logic [2*W-1:0]    rsp_data,
    output logic [W-1:0]      InA,
    output logic              WEN,
    output logic [AW-1:0]     Add2,
    output logic [AW-1:0]     Add0,
    output logic [AW-1:0]     Add1,
    input  logic [W-1:0]      Out0,
    input  logic [W-1:0]      Out1
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_DRD  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    // Last register index for FILL and last pair index for DUMP; the
    // termination tests compare against these instead of relying on wrap.
    localparam logic [AW-1:0] IDX_LAST  = {AW{1'b1}};
    localparam logic [AW-1:0] PAIR_LAST = AW'((32'd1 << (AW - 1)) - 32'd1);

    logic [2:0]        state_q,     state_d;
    logic [1:0]        op_q,        op_d;
    logic [AW-1:0]     addr_q,      addr_d;
    logic [AW-1:0]     addr_b_q,    addr_b_d;
    logic [W-1:0]      data_q,      data_d;
    logic [AW-1:0]     idx_q,       idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [AW-1:0]     rsp_addr_q,  rsp_addr_d;
    logic [2*W-1:0]    rsp_data_q,  rsp_data_d;
    logic              wen_q,       wen_d;
    logic [W-1:0]      ina_q,       ina_d;
    logic [AW-1:0]     add2_q,      add2_d;
    logic [AW-1:0]     add0_q,      add0_d;
    logic [AW-1:0]     add1_q,      add1_d;

    // Even register address of DUMP pair p (AW-bit arithmetic).
    function automatic logic [AW-1:0] pair_base(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        r = p << 1;
        return r;
    endfunction

    // Next-state, field latching and response capture; drive outputs are
    // then decoded from the next state so they come straight from flops.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        addr_b_d   = addr_b_q;
        data_d     = data_q;
        idx_d      = idx_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    addr_d   = cmd_addr;
                    addr_b_d = cmd_addr_b;
                    data_d   = cmd_data;
                    idx_d    = {AW{1'b0}};
                    case (cmd_op)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD;
                        OP_FILL:  state_d = S_FILL;
                        OP_DUMP:  state_d = S_DRD;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
`ifdef REGFILE_ACCESS_WACK_EN
                state_d    = S_RSP;
                rsp_addr_d = addr_q;
                rsp_data_d = {{W{1'b0}}, data_q};
`else
                state_d    = S_IDLE;
`endif
            end
            S_RD: begin
                state_d    = S_RSP;
                rsp_addr_d = addr_q;
                rsp_data_d = {Out1, Out0};
            end
            S_FILL: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + AW'(1'b1);
                    state_d = S_FILL;
                end
            end
            S_DRD: begin
                state_d    = S_RSP;
                rsp_addr_d = pair_base(idx_q);
                rsp_data_d = {Out1, Out0};
            end
            S_RSP: begin
                if (rsp_ready) begin
                    if ((op_q == OP_DUMP) && (idx_q != PAIR_LAST)) begin
                        idx_d   = idx_q + AW'(1'b1);
                        state_d = S_DRD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_RSP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register-file drive values for the state being entered.
    always_comb begin
        wen_d       = 1'b0;
        ina_d       = {W{1'b0}};
        add2_d      = {AW{1'b0}};
        add0_d      = {AW{1'b0}};
        add1_d      = {AW{1'b0}};
        rsp_valid_d = (state_d == S_RSP);

        case (state_d)
            S_WR: begin
                wen_d  = 1'b1;
                add2_d = addr_d;
                ina_d  = data_d;
            end
            S_FILL: begin
                wen_d  = 1'b1;
                add2_d = idx_d;
                ina_d  = data_d;
            end
            S_RD: begin
                add0_d = addr_d;
                add1_d = addr_b_d;
            end
            S_DRD: begin
                add0_d = pair_base(idx_d);
                add1_d = pair_base(idx_d) | AW'(1'b1);
            end
            default: begin
                wen_d = 1'b0;
            end
        endcase
    end

    // State and output flops; synchronous reset aborts any operation.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            addr_q      <= {AW{1'b0}};
            addr_b_q    <= {AW{1'b0}};
            data_q      <= {W{1'b0}};
            idx_q       <= {AW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= {AW{1'b0}};
            rsp_data_q  <= {(2*W){1'b0}};
            wen_q       <= 1'b0;
            ina_q       <= {W{1'b0}};
            add2_q      <= {AW{1'b0}};
            add0_q      <= {AW{1'b0}};
            add1_q      <= {AW{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            addr_b_q    <= addr_b_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            wen_q       <= wen_d;
            ina_q       <= ina_d;
            add2_q      <= add2_d;
            add0_q      <= add0_d;
            add1_q      <= add1_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE) && !RES;
    assign WEN       = wen_q && !RES;
    assign InA       = ina_q;
    assign Add2      = add2_q;
    assign Add0      = add0_q;
    assign Add1      = add1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file as environment,
// a transaction-level model (each command expands into a list of one-cycle
// "work" phases and handshake-held "response" phases), directed scenarios
// with literal expectations, then randomized traffic.
module tb_regfile_access_ctrl;
    localparam int W  = 4;
    localparam int AW = 2;
    localparam int N  = 1 << AW;

    logic              CLK = 1'b0;
    logic              RES;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [AW-1:0]     cmd_addr;
    logic [AW-1:0]     cmd_addr_b;
    logic [W-1:0]      cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [AW-1:0]     rsp_addr;
    logic [2*W-1:0]    rsp_data;
    logic [W-1:0]      InA;
    logic              WEN;
    logic [AW-1:0]     Add2;
    logic [AW-1:0]     Add0;
    logic [AW-1:0]     Add1;
    logic [W-1:0]      Out0;
    logic [W-1:0]      Out1;

    regfile_access_ctrl #(.W(W), .AW(AW)) dut (
        .CLK(CLK), .RES(RES),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .InA(InA), .WEN(WEN), .Add2(Add2), .Add0(Add0), .Add1(Add1),
        .Out0(Out0), .Out1(Out1)
    );

    always #5 CLK = ~CLK;

    // Environment register file
    logic [W-1:0] rf [N];
    always @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < N; i++) rf[i] <= '0;
        end else if (WEN) begin
            rf[Add2] <= InA;
        end
    end
    assign Out0 = rf[Add0];
    assign Out1 = rf[Add1];

    // Reference model
    typedef struct {
        bit              is_rsp;
        bit              wen;
        logic [AW-1:0]   waddr;
        logic [W-1:0]    wdata;
        bit              rd;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [AW-1:0]   raddr;
        logic [2*W-1:0]  rdata;
    } phase_t;

    phase_t          sched[$];
    logic [W-1:0]    mem [N];
    logic [2*W-1:0]  last_data;
    logic [AW-1:0]   last_addr;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired) t=%0t", name, $time);
    endtask

    function automatic phase_t blank();
        phase_t p;
        p = '{default: '0};
        return p;
    endfunction

    // Expand an accepted command into its phase list.
    task automatic model_accept(input logic [1:0] op, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [W-1:0] d);
        phase_t p;
        case (op)
            2'b00: begin
                p = blank(); p.wen = 1; p.waddr = a; p.wdata = d; sched.push_back(p);
`ifdef REGFILE_ACCESS_WACK_EN
                p = blank(); p.is_rsp = 1; p.raddr = a; p.rdata = {4'h0, d}; sched.push_back(p);
`endif
            end
            2'b01: begin
                p = blank(); p.rd = 1; p.ra0 = a; p.ra1 = b; sched.push_back(p);
                p = blank(); p.is_rsp = 1; p.raddr = a; p.rdata = {mem[b], mem[a]}; sched.push_back(p);
            end
            2'b10: begin
                for (int i = 0; i < N; i++) begin
                    p = blank(); p.wen = 1; p.waddr = AW'(i); p.wdata = d; sched.push_back(p);
                end
            end
            default: begin
                for (int k = 0; k < N / 2; k++) begin
                    p = blank(); p.rd = 1; p.ra0 = AW'(2 * k); p.ra1 = AW'(2 * k + 1); sched.push_back(p);
                    p = blank(); p.is_rsp = 1; p.raddr = AW'(2 * k);
                    p.rdata = {mem[2 * k + 1], mem[2 * k]}; sched.push_back(p);
                end
            end
        endcase
    endtask

    // Effect of the coming rising edge, given the inputs now applied.
    task automatic model_step();
        phase_t g;
        if (RES) begin
            sched.delete();
            for (int i = 0; i < N; i++) mem[i] = '0;
            last_data = '0;
            last_addr = '0;
        end else if (sched.size() != 0) begin
            if (!sched[0].is_rsp) begin
                g = sched[0];
                sched.delete(0);
                if (g.wen) mem[g.waddr] = g.wdata;
                if (sched.size() != 0 && sched[0].is_rsp) begin
                    last_data = sched[0].rdata;
                    last_addr = sched[0].raddr;
                end
            end else if (rsp_ready) begin
                sched.delete(0);
            end
        end else if (cmd_valid) begin
            model_accept(cmd_op, cmd_addr, cmd_addr_b, cmd_data);
        end
    endtask

    // Compare every DUT output and the register file against the model.
    task automatic check_outputs();
        bit busy, work;
        phase_t h;
        busy = (sched.size() != 0);
        h    = busy ? sched[0] : blank();
        work = busy && !h.is_rsp;
        chk("cmd_ready", cmd_ready, !busy && !RES);
        chk("rsp_valid", rsp_valid, busy && h.is_rsp);
        chk("rsp_data",  rsp_data,  last_data);
        chk("rsp_addr",  rsp_addr,  last_addr);
        chk("WEN",  WEN,  work && h.wen && !RES);
        chk("Add2", Add2, (work && h.wen) ? h.waddr : '0);
        chk("InA",  InA,  (work && h.wen) ? h.wdata : '0);
        chk("Add0", Add0, (work && h.rd) ? h.ra0 : '0);
        chk("Add1", Add1, (work && h.rd) ? h.ra1 : '0);
        for (int i = 0; i < N; i++) chk("regfile", rf[i], mem[i]);
    endtask

    // One clock: inputs are already applied at the falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(negedge CLK);
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [W-1:0] d);
        bit acc;
        bit done;
        done = 0;
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_addr_b = b; cmd_data = d;
        for (int i = 0; i < 200 && !done; i++) begin
            acc = (sched.size() == 0) && !RES;
            cycle();
            done = acc;
        end
        cmd_valid = 0;
        if (!done) fail_now("issue_timeout");
    endtask

    task automatic wait_rsp(input string name, input logic [2*W-1:0] d, input logic [AW-1:0] a);
        bit seen;
        seen = 0;
        rsp_ready = 1;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
                chk({name, "_data"}, rsp_data, d);
                chk({name, "_addr"}, rsp_addr, a);
            end
            cycle();
        end
        if (!seen) fail_now({name, "_timeout"});
    endtask

    initial begin
        RES = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_addr_b = 0;
        cmd_data = 0; rsp_ready = 0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        last_data = '0; last_addr = '0;
        @(negedge CLK);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        cycle(); cycle();
        RES = 0;
        #1 chk("ready_after_reset", cmd_ready, 1);

        // write/write/read
        rsp_ready = 1;
        issue(2'b00, 2'd0, 2'd0, 4'b1100);
`ifdef REGFILE_ACCESS_WACK_EN
        wait_rsp("wack0", 8'h0C, 2'd0);
`endif
        issue(2'b00, 2'd1, 2'd0, 4'b0011);
`ifdef REGFILE_ACCESS_WACK_EN
        wait_rsp("wack1", 8'h03, 2'd1);
`endif
        issue(2'b01, 2'd0, 2'd1, 4'h0);
        chk("rd_state_no_valid", rsp_valid, 0);
        wait_rsp("rd01", 8'b0011_1100, 2'd0);

        // fill then dump
        issue(2'b10, 2'd0, 2'd0, 4'hA);
        issue(2'b11, 2'd0, 2'd0, 4'h0);
        wait_rsp("dump0", 8'hAA, 2'd0);
        wait_rsp("dump1", 8'hAA, 2'd2);
        chk("dump_done_ready", cmd_ready, 1);

        // stalled response
        issue(2'b00, 2'd3, 2'd0, 4'b0001);
`ifdef REGFILE_ACCESS_WACK_EN
        wait_rsp("wack3", 8'h01, 2'd3);
`endif
        rsp_ready = 0;
        issue(2'b01, 2'd3, 2'd3, 4'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 8'h11);
            chk("stall_ready", cmd_ready, 0);
            cycle();
        end
        wait_rsp("rd33", 8'h11, 2'd3);
        chk("single_handshake", rsp_valid, 0);
        chk("after_rd33_ready", cmd_ready, 1);

        // reset in the middle of a fill
        issue(2'b10, 2'd0, 2'd0, 4'h5);
        cycle(); cycle();
        RES = 1;
        #1 chk("wen_in_reset", WEN, 0);
        cycle();
        RES = 0;
        #1;
        chk("valid_after_reset", rsp_valid, 0);
        chk("ready_after_abort", cmd_ready, 1);
        issue(2'b11, 2'd0, 2'd0, 4'h0);
        wait_rsp("dumpz0", 8'h00, 2'd0);
        wait_rsp("dumpz1", 8'h00, 2'd2);

        // command offered during reset is ignored
        RES = 1; cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 2'd1; cmd_data = 4'hF;
        #1 chk("ready_in_reset", cmd_ready, 0);
        cycle(); cycle();
        RES = 0; cmd_valid = 0;
        cycle();
        issue(2'b01, 2'd1, 2'd1, 4'h0);
        wait_rsp("no_write_in_reset", 8'h00, 2'd1);

        // write acknowledge (or its absence)
        rsp_ready = 1;
        issue(2'b00, 2'd2, 2'd0, 4'h7);
`ifdef REGFILE_ACCESS_WACK_EN
        wait_rsp("wack2", 8'h07, 2'd2);
`else
        for (int i = 0; i < 4; i++) begin
            chk("no_wack_valid", rsp_valid, 0);
            cycle();
        end
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RES        = ($urandom_range(0, 59) == 0);
            cmd_valid  = $urandom_range(0, 1);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_addr   = AW'($urandom_range(0, N - 1));
            cmd_addr_b = AW'($urandom_range(0, N - 1));
            cmd_data   = W'($urandom_range(0, (1 << W) - 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cmd_valid = 0;
        RES = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
